// File: rtl/uart_hex_decoder.sv
// rtl/uart_hex_decoder.sv - parses "<cmd><0..8 hex>CR/LF" bytes into {code, data} bus words
// Optional build macro: UART_HEX_DEC_LOWERCASE_EN (accepts lowercase commands and hex digits)
module uart_hex_decoder #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_stb,
  output logic [33:0] o_word,
  output logic        o_wb_we,
  input  logic        i_busy,
  output logic        o_err,
  output logic        o_idle
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_code, w_code_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [33:0] r_word;
  logic        r_we;
  logic        r_err_defer;

  logic       w_is_hex, w_is_cmd, w_is_term, w_is_space;
  logic [3:0] w_nib;
  logic [1:0] w_cmd;
  logic       w_emit, w_err_now;

  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'd0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = i_rx_data[3:0];
    end else if (i_rx_data >= 8'h41 && i_rx_data <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = i_rx_data[3:0] + 4'd9;
`ifdef UART_HEX_DEC_LOWERCASE_EN
    end else if (i_rx_data >= 8'h61 && i_rx_data <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = i_rx_data[3:0] + 4'd9;
`endif
    end
  end

  always_comb begin
    w_is_cmd = 1'b1;
    w_cmd    = 2'b00;
    case (i_rx_data)
      8'h41: w_cmd = 2'b01;
      8'h57: w_cmd = 2'b00;
      8'h52: w_cmd = 2'b10;
`ifdef UART_HEX_DEC_LOWERCASE_EN
      8'h61: w_cmd = 2'b01;
      8'h77: w_cmd = 2'b00;
      8'h72: w_cmd = 2'b10;
`endif
      default: w_is_cmd = 1'b0;
    endcase
  end

  assign w_is_term  = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
  assign w_is_space = (i_rx_data == 8'h20);

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_err_now   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_stb) begin
          if (w_is_cmd) begin
            w_code_nxt  = w_cmd;
            w_acc_nxt   = 32'd0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_ACCUM;
          end else if (!(w_is_term || w_is_space)) begin
            w_err_now = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        // Hex check comes first so that 'A' is a digit here, not a new command.
        if (i_rx_stb) begin
          if (w_is_hex) begin
            if (r_cnt < MAX_CNT) begin
              w_acc_nxt = {r_acc[27:0], w_nib};
              w_cnt_nxt = r_cnt + 4'd1;
            end else begin
              w_err_now   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else if (w_is_term) begin
            w_state_nxt = S_EMIT;
          end else if (w_is_cmd && w_cmd != 2'b01) begin
            w_err_now  = 1'b1;
            w_code_nxt = w_cmd;
            w_acc_nxt  = 32'd0;
            w_cnt_nxt  = 4'd0;
          end else begin
            w_err_now   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (!i_busy) begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        if (i_rx_stb) w_err_now = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_code      <= 2'b00;
      r_acc       <= 32'd0;
      r_cnt       <= 4'd0;
      r_word      <= 34'd0;
      r_we        <= 1'b0;
      r_err_defer <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_defer <= w_err_now && w_emit;
      if (w_emit) begin
        r_word <= {r_code, r_acc};
        r_we   <= (r_code == 2'b00);
      end
    end
  end

  // A byte dropped in the emit cycle has its error pulse pushed one cycle later.
  assign o_stb   = w_emit;
  assign o_err   = (w_err_now && !w_emit) || r_err_defer;
  assign o_word  = w_emit ? {r_code, r_acc} : r_word;
  assign o_wb_we = w_emit ? (r_code == 2'b00) : r_we;
  assign o_idle  = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_hex_decoder.sv
// tb/tb_uart_hex_decoder.sv - self-checking bench for uart_hex_decoder
module tb_uart_hex_decoder;
  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rx_stb = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_busy = 1'b0;
  logic        o_stb, o_wb_we, o_err, o_idle;
  logic [33:0] o_word;

  int total = 0;
  int bad = 0;
  int n_stb = 0;
  int n_err = 0;
  int n_overlap = 0;
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  uart_hex_decoder #(.MAX_DIGITS(MAXD)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_stb(o_stb), .o_word(o_word), .o_wb_we(o_wb_we), .i_busy(i_busy),
    .o_err(o_err), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_stb) begin
      n_stb++;
      got_q.push_back({o_wb_we, o_word});
    end
    if (o_err) n_err++;
    if (o_stb && o_err) n_overlap++;
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_stb  = 1'b1;
    @(posedge clk); #1;
    i_rx_stb  = 1'b0;
    i_rx_data = 8'd0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference parser: command state expressed as an open/closed text command
  bit          m_open;
  logic [1:0]  m_code;
  logic [31:0] m_val;
  int          m_n;
  int          m_err;

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
`ifdef UART_HEX_DEC_LOWERCASE_EN
    if (b >= "a" && b <= "f") return int'(b) - 87;
`endif
    return -1;
  endfunction

  function automatic int cmdcode(input logic [7:0] b);
    if (b == "W") return 0;
    if (b == "A") return 1;
    if (b == "R") return 2;
`ifdef UART_HEX_DEC_LOWERCASE_EN
    if (b == "w") return 0;
    if (b == "a") return 1;
    if (b == "r") return 2;
`endif
    return -1;
  endfunction

  function automatic bit model_byte(input logic [7:0] b);
    int c = cmdcode(b);
    int h = hexval(b);
    bit term = (b == 8'h0D) || (b == 8'h0A);
    if (!m_open) begin
      if (c >= 0) begin
        m_open = 1; m_code = 2'(c); m_val = 0; m_n = 0;
      end else if (!(term || b == 8'h20)) m_err++;
      return 0;
    end
    if (h >= 0) begin
      if (m_n == MAXD) begin m_err++; m_open = 0; end
      else begin m_val = m_val * 16 + 32'(h); m_n++; end
    end else if (term) begin
      exp_q.push_back({m_code == 2'b00, m_code, m_val});
      m_open = 0;
      return 1;
    end else if (c == 0 || c == 2) begin
      m_err++; m_code = 2'(c); m_val = 0; m_n = 0;
    end else begin
      m_err++; m_open = 0;
    end
    return 0;
  endfunction

  task automatic test_reset();
    i_reset = 1'b1;
    idle(2);
    @(negedge clk);
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", o_idle); end
    total++; if (o_stb !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL reset_pulses stb=%b err=%b want 0 0", o_stb, o_err); end
    total++; if (o_word !== 34'd0 || o_wb_we !== 1'b0) begin bad++; $display("FAIL reset_word got=%h we=%b want 0 0", o_word, o_wb_we); end
    i_reset = 1'b0;
    idle(1);
  endtask

  task automatic test_write();
    int e0 = n_err;
    send_str("W1A\r");
    @(negedge clk);
    total++; if (o_stb !== 1'b1) begin bad++; $display("FAIL write_latency stb=%b want 1", o_stb); end
    total++; if (o_word !== 34'h0_0000_001A || o_wb_we !== 1'b1) begin bad++; $display("FAIL write_word got=%h we=%b want 00000001a 1", o_word, o_wb_we); end
    idle(1);
    @(negedge clk);
    total++; if (o_stb !== 1'b0 || o_word !== 34'h0_0000_001A) begin bad++; $display("FAIL write_hold stb=%b word=%h want 0 00000001a", o_stb, o_word); end
    total++; if (n_err != e0) begin bad++; $display("FAIL write_noerr got=%0d want=0", n_err - e0); end
    idle(1);
  endtask

  task automatic test_addr_read();
    send_str("A12345678\n");
    @(negedge clk);
    total++; if (o_stb !== 1'b1 || o_word !== {2'b01, 32'h12345678} || o_wb_we !== 1'b0) begin bad++; $display("FAIL addr_word stb=%b got=%h we=%b want 1 %h 0", o_stb, o_word, o_wb_we, {2'b01, 32'h12345678}); end
    idle(2);
    send_str("R\r");
    @(negedge clk);
    total++; if (o_stb !== 1'b1 || o_word !== {2'b10, 32'h0} || o_wb_we !== 1'b0) begin bad++; $display("FAIL read_zero stb=%b got=%h we=%b want 1 %h 0", o_stb, o_word, o_wb_we, {2'b10, 32'h0}); end
    idle(2);
  endtask

  task automatic test_overflow();
    int s0 = n_stb;
    int e0 = n_err;
    send_str("W123456789");
    @(negedge clk);
    total++; if (n_err - e0 != 1 || o_idle !== 1'b1) begin bad++; $display("FAIL overflow_err errs=%0d idle=%b want 1 1", n_err - e0, o_idle); end
    idle(1);
    send_str("\r");
    idle(3);
    total++; if (n_stb != s0 || n_err - e0 != 1) begin bad++; $display("FAIL overflow_noemit stbs=%0d errs=%0d want 0 1", n_stb - s0, n_err - e0); end
  endtask

  task automatic test_busy();
    int s0 = n_stb;
    int e0 = n_err;
    i_busy = 1'b1;
    send_str("RFF\r");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) send_byte("W");
      else idle(1);
    end
    total++; if (n_stb != s0 || n_err - e0 != 1 || o_idle !== 1'b0) begin bad++; $display("FAIL busy_hold stbs=%0d errs=%0d idle=%b want 0 1 0", n_stb - s0, n_err - e0, o_idle); end
    i_busy = 1'b0;
    @(negedge clk);
    total++; if (o_stb !== 1'b1 || o_word !== {2'b10, 32'hFF}) begin bad++; $display("FAIL busy_release stb=%b got=%h want 1 %h", o_stb, o_word, {2'b10, 32'hFF}); end
    idle(3);
    total++; if (n_stb - s0 != 1) begin bad++; $display("FAIL busy_once got=%0d want=1", n_stb - s0); end
  endtask

  task automatic test_reset_mid();
    int s0 = n_stb;
    send_str("WAB");
    i_reset = 1'b1;
    #2;
    total++; if (o_idle !== 1'b1 || o_word !== 34'd0) begin bad++; $display("FAIL midreset_state idle=%b word=%h want 1 0", o_idle, o_word); end
    idle(1);
    i_reset = 1'b0;
    idle(1);
    send_str("R7\r");
    @(negedge clk);
    total++; if (o_stb !== 1'b1 || o_word !== {2'b10, 32'h7}) begin bad++; $display("FAIL midreset_next stb=%b got=%h want 1 %h", o_stb, o_word, {2'b10, 32'h7}); end
    idle(2);
    total++; if (n_stb - s0 != 1) begin bad++; $display("FAIL midreset_count got=%0d want=1", n_stb - s0); end
  endtask

  task automatic test_lowercase();
    int s0 = n_stb;
    int e0 = n_err;
    got_q.delete();
    send_str("w1f\r");
    idle(3);
`ifdef UART_HEX_DEC_LOWERCASE_EN
    total++; if (n_stb - s0 != 1 || got_q.size() != 1 || got_q[0] !== {1'b1, 2'b00, 32'h1F}) begin bad++; $display("FAIL lower_word stbs=%0d want 1 word 1f we 1", n_stb - s0); end
    total++; if (n_err != e0) begin bad++; $display("FAIL lower_noerr got=%0d want=0", n_err - e0); end
`else
    total++; if (n_stb != s0) begin bad++; $display("FAIL lower_noemit got=%0d want=0", n_stb - s0); end
    total++; if (n_err - e0 != 3) begin bad++; $display("FAIL lower_errs got=%0d want=3", n_err - e0); end
`endif
  endtask

  task automatic test_back_to_back();
    int s0 = n_stb;
    int e0 = n_err;
    int o0 = n_overlap;
    got_q.delete();
    send_str("A5\r");
    idle(1);
    send_str("W7\r");
    send_byte(" ");
    idle(3);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {1'b0, 2'b01, 32'h5} || got_q[1] !== {1'b1, 2'b00, 32'h7}) begin bad++; $display("FAIL b2b_words got=%h %h want %h %h", got_q[0], got_q[1], {1'b0, 2'b01, 32'h5}, {1'b1, 2'b00, 32'h7}); end
    end
    total++; if (n_err - e0 != 1 || n_overlap != o0) begin bad++; $display("FAIL b2b_err errs=%0d overlap=%0d want 1 0", n_err - e0, n_overlap - o0); end
    total++; if (n_stb - s0 != 2) begin bad++; $display("FAIL b2b_stbs got=%0d want=2", n_stb - s0); end
  endtask

  task automatic test_random();
    string alpha = "0123456789ABCDEF0123456789WRWAR\r\n\r G x a";
    int e0 = n_err;
    int o0 = n_overlap;
    logic [7:0] b;
    got_q.delete();
    exp_q.delete();
    m_open = 0; m_err = 0; m_n = 0; m_val = 0; m_code = 0;
    for (int i = 0; i < 600; i++) begin
      b = alpha[$urandom_range(0, alpha.len() - 1)];
      send_byte(b);
      if (model_byte(b)) idle(1);
    end
    send_str("\r");
    void'(model_byte(8'h0D));
    idle(3);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word idx=%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (n_err - e0 != m_err) begin bad++; $display("FAIL rand_errs got=%0d want=%0d", n_err - e0, m_err); end
    total++; if (n_overlap != o0) begin bad++; $display("FAIL rand_overlap got=%0d want=0", n_overlap - o0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_read();
    test_overflow();
    test_busy();
    test_reset_mid();
    test_lowercase();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
